c2h_cmpt_gen: RTL and testbench

Pass-through stage between the C2H traffic generator and the QDMA C2H stream port. It forwards every beat unchanged, sizes each packet from its byte enables, and flags malformed packets. For each packet it emits one 128-bit completion entry on a valid/ready CMPT interface, and it keeps running packet, byte and error statistics for the register file.

---
 rtl/c2h_cmpt_gen_if.sv | 33 +++
 rtl/c2h_cmpt_gen.sv | 178 +++++++++++++++++
 tb/tb_c2h_cmpt_gen.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c2h_cmpt_gen_if.sv
// Stream and completion handshake bundle for c2h_cmpt_gen.
// master = the surrounding logic (traffic generator, QDMA), slave = c2h_cmpt_gen.
interface c2h_cmpt_gen_if #(
  parameter int RX_LEN = 512,
  parameter int RX_BEN = RX_LEN / 8
);
  // Traffic generator -> stage
  logic              s_rx_valid;
  logic [RX_LEN-1:0] s_rx_data;
  logic [RX_BEN-1:0] s_rx_ben;
  logic              s_rx_last;
  logic              s_rx_ready;
  // Stage -> QDMA C2H stream
  logic              m_rx_valid;
  logic [RX_LEN-1:0] m_rx_data;
  logic [RX_BEN-1:0] m_rx_ben;
  logic              m_rx_last;
  logic              m_rx_ready;
  // Completion entries
  logic              cmpt_valid;
  logic [127:0]      cmpt_data;
  logic              cmpt_ready;

  modport master (
    output s_rx_valid, s_rx_data, s_rx_ben, s_rx_last, m_rx_ready, cmpt_ready,
    input  s_rx_ready, m_rx_valid, m_rx_data, m_rx_ben, m_rx_last, cmpt_valid, cmpt_data
  );

  modport slave (
    input  s_rx_valid, s_rx_data, s_rx_ben, s_rx_last, m_rx_ready, cmpt_ready,
    output s_rx_ready, m_rx_valid, m_rx_data, m_rx_ben, m_rx_last, cmpt_valid, cmpt_data
  );
endinterface

// File: rtl/c2h_cmpt_gen.sv
// C2H pass-through stage: forwards beats unchanged, sizes each packet from its
// byte enables, flags malformed packets, queues one 128-bit completion per
// packet and keeps packet/byte/error statistics.
module c2h_cmpt_gen #(
  parameter int RX_LEN     = 512,
  parameter int RX_BEN     = RX_LEN / 8,
  parameter int QID_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  input  logic [QID_W-1:0] qid,
  input  logic             stat_clr,
  c2h_cmpt_gen_if.slave    bus,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      byte_cnt,
  output logic [15:0]      err_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BSW = $clog2(RX_BEN + 1);
  localparam int EW  = 1 + QID_W + 32;   // {err, qid, seq, len}

  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]        fifo_cnt;
  logic               full, empty, accept, push, pop;
  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]      head, push_entry;

  logic [15:0]        len_q, len_d, seq_q, seq_d;
  logic               err_q, err_d, in_pkt_q, in_pkt_d;
  logic [QID_W-1:0]   qid_q, qid_d, qid_pkt;

  logic [BSW-1:0]     beat_size;
  logic [RX_BEN-1:0]  ben_inc;
  logic               noncontig, len_sat, beat_err, pkt_err;
  logic [16:0]        len_sum;
  logic [15:0]        len_new;

  logic               cmpt_valid_q;
  logic [127:0]       cmpt_data_q, cmpt_d;

  logic [31:0]        pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d, pkt_base, byte_base;
  logic [15:0]        err_cnt_q, err_cnt_d, err_base;

  // Zero-latency data path; only the handshake is gated by FIFO fullness.
  assign fifo_cnt       = wr_ptr_q - rd_ptr_q;
  assign full           = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign empty          = (wr_ptr_q == rd_ptr_q);
  assign bus.m_rx_data  = bus.s_rx_data;
  assign bus.m_rx_ben   = bus.s_rx_ben;
  assign bus.m_rx_last  = bus.s_rx_last;
  assign bus.m_rx_valid = bus.s_rx_valid & ~full;
  assign bus.s_rx_ready = bus.m_rx_ready & ~full;
  assign accept         = bus.s_rx_valid & bus.s_rx_ready;
  assign push           = accept & bus.s_rx_last;
  assign pop            = ~empty & (~cmpt_valid_q | bus.cmpt_ready);

  // Beat size, ben sanity and the saturating length sum for the current beat.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    beat_size = '0;
    for (int i = 0; i < RX_BEN; i++) beat_size = beat_size + BSW'(bus.s_rx_ben[i]);
    ben_inc    = bus.s_rx_ben + RX_BEN'(1);
    noncontig  = |(bus.s_rx_ben & ben_inc);   // zero only for 0..01..1 patterns
    len_sum    = {1'b0, len_q} + 17'(beat_size);
    len_sat    = len_sum[16];
    len_new    = len_sat ? 16'hFFFF : len_sum[15:0];
    beat_err   = (~bus.s_rx_last & ~&bus.s_rx_ben) | noncontig | len_sat;
    pkt_err    = err_q | beat_err;
    qid_pkt    = in_pkt_q ? qid_q : qid;      // single-beat packets use qid directly
    push_entry = {pkt_err, qid_pkt, seq_q, len_new};
  end

  // Packet accumulation: length, sticky error, captured qid, sequence number.
  always_comb begin
    len_d    = len_q;
    err_d    = err_q;
    in_pkt_d = in_pkt_q;
    qid_d    = qid_q;
    seq_d    = seq_q;
    if (accept) begin
      if (bus.s_rx_last) begin
        len_d    = '0;
        err_d    = 1'b0;
        in_pkt_d = 1'b0;
        seq_d    = seq_q + 16'd1;
      end else begin
        len_d    = len_new;
        err_d    = pkt_err;
        in_pkt_d = 1'b1;
        if (!in_pkt_q) qid_d = qid;
      end
    end
  end

  // Packet state and FIFO pointer registers.
  always_ff @(posedge axi_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (axi_areset) begin
      len_q    <= '0;
      err_q    <= 1'b0;
      in_pkt_q <= 1'b0;
      qid_q    <= '0;
      seq_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      len_q    <= len_d;
      err_q    <= err_d;
      in_pkt_q <= in_pkt_d;
      qid_q    <= qid_d;
      seq_q    <= seq_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Pending-completion storage.
  always_ff @(posedge axi_aclk) begin
    // NOTE: storage array is not reset; the pointers alone define which entries are valid.
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // Map the FIFO head onto the completion entry layout.
  always_comb begin
    head                  = fifo_mem[rd_ptr_q[AW-1:0]];
    cmpt_d                = '0;
    cmpt_d[15:0]          = head[15:0];
    cmpt_d[31:16]         = head[31:16];
    cmpt_d[31+QID_W:32]   = head[32 +: QID_W];
    cmpt_d[48]            = head[EW-1];
  end

  // Completion output register: load on pop, hold until accepted.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      cmpt_valid_q <= 1'b0;
      cmpt_data_q  <= '0;
    end else if (pop) begin
      cmpt_valid_q <= 1'b1;
      cmpt_data_q  <= cmpt_d;
    end else if (bus.cmpt_ready) begin
      cmpt_valid_q <= 1'b0;
    end
  end

  assign bus.cmpt_valid = cmpt_valid_q;
  assign bus.cmpt_data  = cmpt_data_q;

  // Statistics next-state; a clear restarts from zero but still takes this cycle's increment.
  always_comb begin
    pkt_base   = stat_clr ? 32'd0 : pkt_cnt_q;
    byte_base  = stat_clr ? 32'd0 : byte_cnt_q;
    err_base   = stat_clr ? 16'd0 : err_cnt_q;
    pkt_cnt_d  = pkt_base + {31'd0, push};
    byte_cnt_d = byte_base + (accept ? 32'(beat_size) : 32'd0);
    err_cnt_d  = (push && pkt_err && err_base != 16'hFFFF) ? err_base + 16'd1 : err_base;
  end

  // Statistics registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign byte_cnt = byte_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_c2h_cmpt_gen.sv
// Self-checking bench for c2h_cmpt_gen: a packet-level reference model pushes
// expected completions into a queue; a monitor pops and compares on handshake.
module tb_c2h_cmpt_gen;
  localparam int RX_LEN     = 512;
  localparam int RX_BEN     = 64;
  localparam int QID_W      = 11;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [QID_W-1:0] qid;
  logic             stat_clr;
  logic [31:0]      pkt_cnt, byte_cnt;
  logic [15:0]      err_cnt;

  c2h_cmpt_gen_if #(.RX_LEN(RX_LEN), .RX_BEN(RX_BEN)) bus ();

  c2h_cmpt_gen #(
    .RX_LEN(RX_LEN), .RX_BEN(RX_BEN), .QID_W(QID_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst), .qid(qid), .stat_clr(stat_clr),
    .bus(bus), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;
  int rdy_mode = 1;   // 0: cmpt_ready low, 1: high, 2: random (m_rx_ready also random)

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  logic [127:0]     exp_q[$];
  int               m_len;
  bit               m_err, m_in_pkt;
  logic [QID_W-1:0] m_qid;
  logic [15:0]      m_seq;
  logic [31:0]      m_pkt, m_byte;
  logic [15:0]      m_errc;

  task automatic model_reset();
    exp_q.delete();
    m_len = 0; m_err = 0; m_in_pkt = 0; m_qid = '0; m_seq = '0;
    m_pkt = '0; m_byte = '0; m_errc = '0;
  endtask

  task automatic model_beat(input logic [RX_BEN-1:0] ben, input bit last, input bit clr);
    int sz;
    logic [RX_BEN-1:0] mask;
    logic [127:0] e;
    bit err;
    sz   = $countones(ben);
    mask = (sz == RX_BEN) ? '1 : ((RX_BEN'(1) << sz) - RX_BEN'(1));
    if (clr) begin m_pkt = '0; m_byte = '0; m_errc = '0; end
    if (!m_in_pkt) begin m_in_pkt = 1; m_qid = qid; m_len = 0; m_err = 0; end
    m_len += sz;
    if (ben != mask) m_err = 1;
    if (!last && ben != {RX_BEN{1'b1}}) m_err = 1;
    m_byte = m_byte + 32'(sz);
    if (last) begin
      err       = m_err || (m_len > 65535);
      e         = '0;
      e[15:0]   = (m_len > 65535) ? 16'hFFFF : 16'(m_len);
      e[31:16]  = m_seq;
      e[32 +: QID_W] = m_qid;
      e[48]     = err;
      exp_q.push_back(e);
      m_seq = m_seq + 16'd1;
      m_pkt = m_pkt + 32'd1;
      if (err && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
      m_in_pkt = 0;
    end
  endtask

  function automatic logic [RX_BEN-1:0] mask_of(input int sz);
    return (sz >= RX_BEN) ? '1 : ((RX_BEN'(1) << sz) - RX_BEN'(1));
  endfunction

  function automatic logic [RX_BEN-1:0] rand_ben(input bit is_last);
    logic [RX_BEN-1:0] b;
    if (!is_last && $urandom_range(0, 7) != 0) return '1;
    b = mask_of($urandom_range(0, RX_BEN));
    if ($urandom_range(0, 7) == 0) b = {$urandom, $urandom};
    return b;
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.cmpt_ready = 1'b0;
      1:       bus.cmpt_ready = 1'b1;
      default: bus.cmpt_ready = 1'($urandom_range(0, 1));
    endcase
    bus.m_rx_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Present one beat until accepted; called at posedge+#1, returns at posedge+#1.
  task automatic send_beat(input logic [RX_BEN-1:0] ben, input bit last, output int stalls);
    bit done;
    done   = 0;
    stalls = 0;
    bus.s_rx_valid = 1'b1;
    for (int w = 0; w < RX_LEN / 32; w++) bus.s_rx_data[w*32 +: 32] = $urandom;
    bus.s_rx_ben  = ben;
    bus.s_rx_last = last;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      check("pass_through", {127'd0, (bus.m_rx_data == bus.s_rx_data) &&
            (bus.m_rx_ben == bus.s_rx_ben) && (bus.m_rx_last == bus.s_rx_last)}, 128'd1);
      if (bus.m_rx_ready) check("m_rx_valid", bus.m_rx_valid, bus.s_rx_ready);
      if (bus.s_rx_ready) done = 1; else stalls++;
      @(posedge clk);
      if (done) model_beat(ben, last, stat_clr);
    end
    if (!done) check("beat_accept_timeout", 0, 1);
    #1;
    bus.s_rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [RX_BEN-1:0] last_ben, output int stalls);
    int s;
    stalls = 0;
    for (int b = 0; b < nbeats - 1; b++) begin send_beat('1, 1'b0, s); stalls += s; end
    send_beat(last_ben, 1'b1, s);
    stalls += s;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.cmpt_valid) ok = 1;
    end
    check("drain", {127'd0, ok}, 128'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [127:0] held;
  bit           held_v = 0;
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        check("cmpt_hold_valid", bus.cmpt_valid, 1);
        check("cmpt_hold_data", bus.cmpt_data, held);
      end
      held_v = bus.cmpt_valid && !bus.cmpt_ready;
      held   = bus.cmpt_data;
      if (bus.cmpt_valid && bus.cmpt_ready) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmpt_unexpected: got %0h expected none", bus.cmpt_data);
        end else begin
          e = exp_q.pop_front();
          check("cmpt_entry", bus.cmpt_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st, tot, p0;
    rst = 1'b1; qid = '0; stat_clr = 1'b0;
    bus.s_rx_valid = 1'b0; bus.s_rx_data = '0; bus.s_rx_ben = '0; bus.s_rx_last = 1'b0;
    bus.m_rx_ready = 1'b1; bus.cmpt_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmpt_valid", bus.cmpt_valid, 0);
    check("rst_cmpt_data", bus.cmpt_data, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_s_rx_ready", bus.s_rx_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single 1518-byte packet: 23 full beats + 46-byte tail.
    qid = 11'd5;
    send_pkt(24, mask_of(46), st);
    check("lat_edge_n", bus.cmpt_valid, 0);
    @(posedge clk); #1;
    check("lat_edge_n1", bus.cmpt_valid, 1);
    check("single_len", bus.cmpt_data[15:0], 16'd1518);
    check("single_qid", bus.cmpt_data[31+QID_W:32], 11'd5);
    check("single_err", bus.cmpt_data[48], 0);
    wait_drain();
    check("single_byte_cnt", byte_cnt, 32'd1518);
    check("single_pkt_cnt", pkt_cnt, 32'd1);

    // Back-to-back single-beat packets after a stand-alone clear.
    stat_clr = 1'b1;
    @(posedge clk);
    model_beat('0, 1'b0, 1'b1); m_in_pkt = 0;   // clear only: zero-byte, no packet
    #1 stat_clr = 1'b0;
    tot = 0;
    for (int i = 0; i < 20; i++) begin qid = QID_W'(i); send_beat('1, 1'b1, st); tot += st; end
    check("b2b_no_stall", tot, 0);
    wait_drain();
    check("b2b_byte_cnt", byte_cnt, 32'd1280);
    check("b2b_pkt_cnt", pkt_cnt, 32'd20);

    // Completion backpressure: 9 accepted, 10th blocked until cmpt_ready rises.
    rdy_mode = 0;
    @(posedge clk); #1;
    p0 = n_popped;
    for (int i = 0; i < 9; i++) begin qid = QID_W'(100 + i); send_beat('1, 1'b1, st); end
    bus.s_rx_valid = 1'b1; bus.s_rx_ben = '1; bus.s_rx_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_s_rx_ready", bus.s_rx_ready, 0);
      check("bp_m_rx_valid", bus.m_rx_valid, 0);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int i = 9; i < 12; i++) begin qid = QID_W'(100 + i); send_beat('1, 1'b1, st); end
    wait_drain();
    check("bp_drained_count", n_popped - p0, 12);

    // Malformed packet, then a clean one.
    send_beat(64'h00FF, 1'b0, st);
    send_beat(64'h1, 1'b1, st);
    @(posedge clk); #1;
    check("bad_len", bus.cmpt_data[15:0], 16'd9);
    check("bad_err", bus.cmpt_data[48], 1);
    send_beat(mask_of(10), 1'b1, st);
    wait_drain();
    check("bad_err_cnt", err_cnt, 16'd1);

    // Length boundary: exactly 0xFFFF is clean; one more byte saturates.
    send_pkt(1024, mask_of(63), st);
    send_pkt(1025, mask_of(1), st);
    wait_drain();
    check("sat_err_cnt", err_cnt, m_errc);

    // stat_clr coincident with an accepted 64-byte beat.
    stat_clr = 1'b1;
    send_beat('1, 1'b1, st);
    stat_clr = 1'b0;
    check("clr_byte_cnt", byte_cnt, 32'd64);
    check("clr_pkt_cnt", pkt_cnt, 32'd1);
    check("clr_err_cnt", err_cnt, 16'd0);
    wait_drain();

    // Reset in the middle of a packet.
    send_beat('1, 1'b0, st);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("rst2_pkt_cnt", pkt_cnt, 0);
    check("rst2_byte_cnt", byte_cnt, 0);
    check("rst2_cmpt_valid", bus.cmpt_valid, 0);
    qid = 11'd7;
    send_beat(mask_of(20), 1'b1, st);
    @(posedge clk); #1;
    check("rst2_seq", bus.cmpt_data[31:16], 16'd0);
    check("rst2_len", bus.cmpt_data[15:0], 16'd20);
    wait_drain();

    // Randomized traffic with random back-pressure and mid-packet qid changes.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        qid = QID_W'($urandom);
        send_beat(rand_ben(b == nb - 1), b == nb - 1, st);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rdy_mode = 1;
    @(posedge clk); #1;
    wait_drain();
    check("final_pkt_cnt", pkt_cnt, m_pkt);
    check("final_byte_cnt", byte_cnt, m_byte);
    check("final_err_cnt", err_cnt, m_errc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
